// File: rtl/hazard_ctrl_mc.sv
// Hazard control for the 5-stage RV32 core: forwarding, load-use/branch hazards, mul/div freeze, perf counters.
// Stall/flush/forward outputs are combinational (same cycle); only the mul/div FSM and the counters are registered.
module hazard_ctrl_mc #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] RS1_d,
    input  logic [REG_AW-1:0] RS2_d,
    input  logic [REG_AW-1:0] RS1_e,
    input  logic [REG_AW-1:0] RS2_e,
    input  logic [REG_AW-1:0] RD_e,
    input  logic [REG_AW-1:0] RD_m,
    input  logic [REG_AW-1:0] RD_w,
    input  logic              RegWrite_m,
    input  logic              RegWrite_w,
    input  logic [1:0]        ResultSrc_e,
    input  logic              PCSrc_e,
    input  logic              MulDiv_e,
    input  logic              MDDone_e,
    output logic [1:0]        ForwardA_e,
    output logic [1:0]        ForwardB_e,
    output logic              Stall_f,
    output logic              Stall_d,
    output logic              Stall_e,
    output logic              Flush_d,
    output logic              Flush_e,
    output logic              Flush_m,
    output logic              MDStart_e,
    output logic              MDBusy,
    output logic [CNT_W-1:0]  StallCount,
    output logic [CNT_W-1:0]  FlushCount
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} md_state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    md_state_t state, state_nxt;
    logic      lw_stall;
    logic      md_stall;
    logic      md_start;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] src,
        input logic [REG_AW-1:0] rd_m,
        input logic              we_m,
        input logic [REG_AW-1:0] rd_w,
        input logic              we_w
    );
        if (we_m && (rd_m != '0) && (src == rd_m))
            return 2'b10;
        else if (we_w && (rd_w != '0) && (src == rd_w))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        ForwardA_e = fwd_sel(RS1_e, RD_m, RegWrite_m, RD_w, RegWrite_w);
        ForwardB_e = fwd_sel(RS2_e, RD_m, RegWrite_m, RD_w, RegWrite_w);
    end

    assign lw_stall = ((RS1_d == RD_e) || (RS2_d == RD_e)) && (RD_e != '0) && (ResultSrc_e == 2'b01);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // A taken branch squashes the mul/div in Execute, so it never starts.
    always_comb begin
        state_nxt = state;
        md_start  = 1'b0;
        md_stall  = 1'b0;
        case (state)
            IDLE: begin
                if (MulDiv_e && !PCSrc_e) begin
                    md_start  = 1'b1;
                    md_stall  = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (MDDone_e)
                    state_nxt = IDLE;
                else
                    md_stall = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // md_stall freezes everything up to Execute and overrides load-use and branch.
    always_comb begin
        Stall_f = 1'b0;
        Stall_d = 1'b0;
        Stall_e = 1'b0;
        Flush_d = 1'b0;
        Flush_e = 1'b0;
        Flush_m = 1'b0;
        if (md_stall) begin
            Stall_f = 1'b1;
            Stall_d = 1'b1;
            Stall_e = 1'b1;
            Flush_m = 1'b1;
        end else begin
            Stall_f = lw_stall;
            Stall_d = lw_stall;
            Flush_d = PCSrc_e;
            Flush_e = lw_stall | PCSrc_e;
        end
    end

    assign MDStart_e = md_start;
    assign MDBusy    = (state == BUSY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            if (Stall_f && (StallCount != '1))
                StallCount <= StallCount + CNT_ONE;
            if (Flush_d && (FlushCount != '1))
                FlushCount <= FlushCount + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
module tb_hazard_ctrl_mc;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] RS1_d, RS2_d, RS1_e, RS2_e, RD_e, RD_m, RD_w;
    logic       RegWrite_m, RegWrite_w, PCSrc_e, MulDiv_e, MDDone_e;
    logic [1:0] ResultSrc_e;

    logic [1:0]  ForwardA_e, ForwardB_e;
    logic        Stall_f, Stall_d, Stall_e, Flush_d, Flush_e, Flush_m, MDStart_e, MDBusy;
    logic [31:0] StallCount, FlushCount;

    logic [1:0]  s_fa, s_fb;
    logic        s_sf, s_sd, s_se, s_fd, s_fe, s_fm, s_start, s_busy;
    logic [3:0]  s_sc, s_fc;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    hazard_ctrl_mc u_dut (
        .clk(clk), .rst_n(rst_n),
        .RS1_d(RS1_d), .RS2_d(RS2_d), .RS1_e(RS1_e), .RS2_e(RS2_e), .RD_e(RD_e),
        .RD_m(RD_m), .RD_w(RD_w), .RegWrite_m(RegWrite_m), .RegWrite_w(RegWrite_w),
        .ResultSrc_e(ResultSrc_e), .PCSrc_e(PCSrc_e), .MulDiv_e(MulDiv_e), .MDDone_e(MDDone_e),
        .ForwardA_e(ForwardA_e), .ForwardB_e(ForwardB_e),
        .Stall_f(Stall_f), .Stall_d(Stall_d), .Stall_e(Stall_e),
        .Flush_d(Flush_d), .Flush_e(Flush_e), .Flush_m(Flush_m),
        .MDStart_e(MDStart_e), .MDBusy(MDBusy), .StallCount(StallCount), .FlushCount(FlushCount)
    );

    hazard_ctrl_mc #(.REG_AW(5), .CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .RS1_d(RS1_d), .RS2_d(RS2_d), .RS1_e(RS1_e), .RS2_e(RS2_e), .RD_e(RD_e),
        .RD_m(RD_m), .RD_w(RD_w), .RegWrite_m(RegWrite_m), .RegWrite_w(RegWrite_w),
        .ResultSrc_e(ResultSrc_e), .PCSrc_e(PCSrc_e), .MulDiv_e(MulDiv_e), .MDDone_e(MDDone_e),
        .ForwardA_e(s_fa), .ForwardB_e(s_fb),
        .Stall_f(s_sf), .Stall_d(s_sd), .Stall_e(s_se),
        .Flush_d(s_fd), .Flush_e(s_fe), .Flush_m(s_fm),
        .MDStart_e(s_start), .MDBusy(s_busy), .StallCount(s_sc), .FlushCount(s_fc)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mul/div "in flight" flag plus integer counters.
    bit     m_busy;
    longint m_sc, m_fc, m_sc4, m_fc4;
    localparam longint MAX32 = 64'hFFFF_FFFF;
    localparam longint MAX4  = 15;

    function automatic logic [1:0] ref_fwd(input logic [4:0] s);
        if (s == RD_m && RegWrite_m && RD_m != 0) return 2'b10;
        if (s == RD_w && RegWrite_w && RD_w != 0) return 2'b01;
        return 2'b00;
    endfunction

    logic e_lw, e_start, e_md, e_sf, e_fd, e_fe;
    assign e_lw    = ((RS1_d == RD_e) || (RS2_d == RD_e)) && (RD_e != 0) && (ResultSrc_e == 2'b01);
    assign e_start = !m_busy && MulDiv_e && !PCSrc_e;
    assign e_md    = e_start || (m_busy && !MDDone_e);
    assign e_sf    = e_md || e_lw;
    assign e_fd    = !e_md && PCSrc_e;
    assign e_fe    = !e_md && (e_lw || PCSrc_e);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_sc <= 0; m_fc <= 0; m_sc4 <= 0; m_fc4 <= 0;
        end else begin
            m_busy <= m_busy ? !MDDone_e : e_start;
            if (e_sf && m_sc  < MAX32) m_sc  <= m_sc + 1;
            if (e_sf && m_sc4 < MAX4)  m_sc4 <= m_sc4 + 1;
            if (e_fd && m_fc  < MAX32) m_fc  <= m_fc + 1;
            if (e_fd && m_fc4 < MAX4)  m_fc4 <= m_fc4 + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_fwdA", ForwardA_e, ref_fwd(RS1_e));
            chk("m_fwdB", ForwardB_e, ref_fwd(RS2_e));
            chk("m_stall_f", Stall_f, e_sf);
            chk("m_stall_d", Stall_d, e_sf);
            chk("m_stall_e", Stall_e, e_md);
            chk("m_flush_d", Flush_d, e_fd);
            chk("m_flush_e", Flush_e, e_fe);
            chk("m_flush_m", Flush_m, e_md);
            chk("m_mdstart", MDStart_e, e_start);
            chk("m_mdbusy", MDBusy, m_busy);
            chk("m_stallcnt", StallCount, m_sc);
            chk("m_flushcnt", FlushCount, m_fc);
            chk("m_stallcnt4", s_sc, m_sc4);
            chk("m_flushcnt4", s_fc, m_fc4);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic clr();
        RS1_d = 0; RS2_d = 0; RS1_e = 0; RS2_e = 0; RD_e = 0; RD_m = 0; RD_w = 0;
        RegWrite_m = 0; RegWrite_w = 0; ResultSrc_e = 0; PCSrc_e = 0; MulDiv_e = 0; MDDone_e = 0;
    endtask

    initial begin
        clr();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk_en = 1'b1;
        chk("rst_mdbusy", MDBusy, 0);
        chk("rst_stallcnt", StallCount, 0);
        chk("rst_stall_f", Stall_f, 0);
        chk("rst_flush_d", Flush_d, 0);
        chk("rst_fwdA", ForwardA_e, 0);
        repeat (2) cyc();
        rst_n = 1'b1;

        // Forwarding priority
        cyc(); RS1_e = 5; RD_m = 5; RD_w = 5; RegWrite_m = 1; RegWrite_w = 1;
        smp(); chk("fwd_m_prio", ForwardA_e, 2'b10);
        cyc(); RD_m = 0;
        smp(); chk("fwd_rdm0", ForwardA_e, 2'b01);
        cyc(); RS2_e = 0; RD_w = 0;
        smp(); chk("fwd_x0", ForwardB_e, 2'b00);
        cyc(); RD_m = 5; RegWrite_m = 0; RD_w = 5; RS2_e = 5;
        smp(); chk("fwd_wem_off", ForwardB_e, 2'b01);

        // Load-use
        cyc(); clr(); ResultSrc_e = 2'b01; RD_e = 7; RS2_d = 7;
        smp(); chk("lu_stall_f", Stall_f, 1); chk("lu_stall_d", Stall_d, 1);
        chk("lu_flush_e", Flush_e, 1); chk("lu_stall_e", Stall_e, 0);
        cyc(); clr();
        smp(); chk("lu_cnt", StallCount, 1); chk("lu_one_bubble", Stall_f, 0);
        cyc(); ResultSrc_e = 2'b01; RD_e = 0;
        smp(); chk("lu_x0", Stall_f, 0);
        cyc(); clr();
        smp(); chk("lu_x0_cnt", StallCount, 1);

        // Branch
        cyc(); PCSrc_e = 1;
        smp(); chk("br_flush_d", Flush_d, 1); chk("br_flush_e", Flush_e, 1); chk("br_stall_f", Stall_f, 0);
        cyc(); PCSrc_e = 0;
        smp(); chk("br_cnt", FlushCount, 1); chk("br_done", Flush_d, 0);
        cyc(); PCSrc_e = 1; MulDiv_e = 1;
        smp(); chk("br_md_nostart", MDStart_e, 0); chk("br_md_flush", Flush_d, 1);
        cyc(); clr();
        smp(); chk("br_md_cnt", FlushCount, 2); chk("br_md_idle", MDBusy, 0);

        // Mul/div latency 4, then back-to-back latency 1
        cyc(); MulDiv_e = 1;
        smp(); chk("md_start_T", MDStart_e, 1); chk("md_stall_e_T", Stall_e, 1);
        chk("md_flush_m_T", Flush_m, 1); chk("md_busy_T", MDBusy, 0);
        for (int i = 1; i <= 3; i++) begin
            cyc();
            if (i == 2) begin PCSrc_e = 1; ResultSrc_e = 2'b01; RD_e = 7; RS2_d = 7; end
            if (i == 3) begin PCSrc_e = 0; ResultSrc_e = 0; RD_e = 0; RS2_d = 0; end
            smp(); chk("md_nostart", MDStart_e, 0); chk("md_stall_f", Stall_f, 1); chk("md_busy", MDBusy, 1);
            if (i == 2) begin chk("md_ovr_flush_d", Flush_d, 0); chk("md_ovr_flush_e", Flush_e, 0); end
        end
        cyc(); MDDone_e = 1;
        smp(); chk("md_done_stall_f", Stall_f, 0); chk("md_done_stall_e", Stall_e, 0);
        chk("md_done_flush_m", Flush_m, 0); chk("md_done_busy", MDBusy, 1); chk("md_done_nostart", MDStart_e, 0);
        cyc(); MDDone_e = 0;
        smp(); chk("b2b_start", MDStart_e, 1); chk("b2b_idle", MDBusy, 0); chk("md_cnt4", StallCount, 5);
        cyc(); MDDone_e = 1;
        smp(); chk("b2b_done", Stall_f, 0); chk("b2b_busy", MDBusy, 1);
        cyc(); clr();
        smp(); chk("b2b_cnt", StallCount, 6); chk("b2b_end", MDBusy, 0); chk("md_no_flushcnt", FlushCount, 2);

        // Reset mid-BUSY
        cyc(); MulDiv_e = 1;
        smp();
        cyc();
        smp(); chk("mr_busy_pre", MDBusy, 1);
        cyc(); clr(); rst_n = 1'b0;
        #1;
        chk("mr_busy", MDBusy, 0); chk("mr_stallcnt", StallCount, 0);
        chk("mr_flushcnt", FlushCount, 0); chk("mr_stallcnt4", s_sc, 0);
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc(); MDDone_e = 1;
        smp(); chk("stray_nostart", MDStart_e, 0); chk("stray_stall", Stall_f, 0);
        cyc(); MDDone_e = 0;
        smp(); chk("stray_busy", MDBusy, 0); chk("stray_cnt", StallCount, 0);

        // Saturation
        for (int i = 0; i < 20; i++) begin
            cyc(); ResultSrc_e = 2'b01; RD_e = 7; RS1_d = 7;
            smp();
        end
        cyc(); clr();
        smp(); chk("sat_cnt4", s_sc, 15); chk("sat_cnt32", StallCount, 20);
        cyc();
        smp(); chk("sat_hold", s_sc, 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
